arithunit_seq: RTL and testbench
================================

Name: arithunit_seq

Overview:
Parametrised successor to the 2-bit-opcode registered arithmetic unit. It performs ADD, SUB, MUL and DIV on unsigned WIDTH-bit operands behind valid/ready handshakes on both input and output.
- ADD/SUB complete in a single cycle.
- MUL and DIV are iterative: one bit per cycle, using a shared shift engine.
- Results carry a high word (MUL upper half or DIV remainder) and status flags.
- Sits between the operand-fetch stage and the writeback register file.

Parameters:
WIDTH, 16, operand and result width in bits (legal range 4 to 32).
CNT_W, $clog2(WIDTH)+1, iteration-counter width (derived; do not override).

Ports:
clk  input  1  system clock; all logic is rising-edge.
reset  input  1  synchronous reset, active-low: reset==0 at a clk rising edge resets the block.
in_valid  input  1  operand/opcode presented.
in_ready  output  1  block can accept a request.
data_1  input  WIDTH  operand A (minuend / dividend / multiplicand).
data_2  input  WIDTH  operand B (subtrahend / divisor / multiplier).
op_sel  input  2  0=ADD, 1=SUB, 2=MUL, 3=DIV.
out_valid  output  1  result available.
out_ready  input  1  consumer takes the result.
data_out  output  WIDTH  sum, difference, product low half, or quotient.
data_out_hi  output  WIDTH  product high half, or remainder; 0 for ADD/SUB.
carry  output  1  ADD carry-out; SUB borrow (A<B); 0 for MUL/DIV.
div_by_zero  output  1  DIV with data_2==0.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - in_ready=1 and out_valid=0.
  - data_out, data_out_hi, carry and div_by_zero all go to 0.
  - Reset overrides everything, including mid-BUSY and a held DONE. Any in-flight result is discarded.
- FSM states: IDLE, BUSY, DONE.
- in_ready is 1 only in IDLE. A request is accepted when in_valid && in_ready at a clk edge; data_1, data_2 and op_sel are captured internally at that edge. Inputs are don't-care outside the accept edge.
- Transitions on accept:
  - ADD/SUB: compute in the accept cycle, go to DONE; out_valid=1 on the next cycle (latency 1).
  - MUL/DIV with data_2!=0: go to BUSY and load counter=WIDTH. Each cycle performs one shift-add (MUL, LSB-first) or restoring subtract-shift (DIV, MSB-first) step and decrements the counter. When counter reaches 0, write the result and go to DONE. out_valid rises exactly WIDTH+1 cycles after the accept edge.
  - DIV with data_2==0: go straight to DONE (latency 1). data_out = all ones, data_out_hi = data_1, div_by_zero=1.
  - MUL by 0 is not short-cut; it takes the full WIDTH cycles.
- DONE:
  - Outputs are stable while out_valid && !out_ready (backpressure of any length).
  - On out_valid && out_ready, go to IDLE with out_valid=0. Outputs keep their last values.
  - A new request may be accepted at the earliest the cycle after the handshake, so peak throughput is one ADD every 2 cycles.
- Arithmetic rules:
  - ADD: {carry, data_out} = A + B, computed WIDTH+1 wide.
  - SUB: data_out = (A − B) mod 2^WIDTH; carry = (A < B).
  - MUL: {data_out_hi, data_out} = A × B, full 2·WIDTH bits.
  - DIV: data_out = A / B, data_out_hi = A % B.
  - Flags not relevant to the operation are 0.
- In BUSY and DONE, in_valid is ignored; the block never accepts while busy.

Decomposition:
- Package arithunit_pkg: opcode localparams OP_ADD=2'd0, OP_SUB=2'd1, OP_MUL=2'd2, OP_DIV=2'd3; FSM state encodings S_IDLE, S_BUSY, S_DONE.
- One sub-module, arith_iter_muldiv: a WIDTH-parametrised shift engine with start, mode, operand load, and a done pulse. It holds the 2·WIDTH accumulator and the counter.
- The top level holds the FSM, the handshake, the ADD/SUB datapath and the output registers.

Test Plan (WIDTH=16):
1. Reset, then ADD 0xFFFF+0x0001 with out_ready=1 → out_valid 1 cycle after accept; data_out=0x0000, carry=1, data_out_hi=0.
2. SUB 3−5 → data_out=0xFFFE, carry=1. SUB 9−4 → data_out=0x0005, carry=0.
3. MUL 0x1234×0x0100 → out_valid exactly 17 cycles after accept; data_out=0x3400, data_out_hi=0x0012; in_ready=0 throughout BUSY.
4. DIV 100/7 → data_out=14, data_out_hi=2, div_by_zero=0, latency 17. DIV 0x00AB/0 → latency 1, data_out=0xFFFF, data_out_hi=0x00AB, div_by_zero=1.
5. ADD 2+3 with out_ready=0 for 5 cycles → out_valid and data_out=5 stable for all 5 cycles; in_ready=0 throughout; in_valid pulses during the stall are ignored. Raise out_ready → in_ready=1 on the next cycle.
6. Start MUL, drive reset=0 on the 6th BUSY cycle → next cycle: in_ready=1, out_valid=0, all outputs 0. A fresh ADD 1+1 afterwards returns 2 with no residue from the aborted MUL.

Source files
------------

// File: rtl/arithunit_pkg.sv
// Shared definitions for the sequential arithmetic unit.
//   OP_*    : 2-bit opcode encodings presented on op_sel.
//   state_e : control FSM states (idle / iterating / result held).
package arithunit_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/arith_iter_muldiv.sv
// Iterative one-bit-per-cycle multiply / divide engine.
// Ports:
//   clk, reset       : clock, synchronous active-low reset
//   start            : load operands and begin WIDTH iterations
//   mode_div         : 0 = unsigned multiply, 1 = unsigned restoring divide
//   op_a, op_b       : multiplicand/dividend and multiplier/divisor
//   done             : high during the final iteration cycle
//   res_lo, res_hi   : result of the current step; valid when done is high
//                      (MUL: product low/high, DIV: quotient/remainder)
module arith_iter_muldiv #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  // acc_q upper half: partial product / partial remainder.
  // acc_q lower half: remaining multiplier bits / dividend bits shifting into quotient.
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   opnd_q;  // multiplicand (MUL) or divisor (DIV)
  logic [CNT_W-1:0]   cnt_q;
  logic               run_q;
  logic               div_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem_sh;
  logic [WIDTH-1:0] div_trial;

  always_comb begin
    // LSB-first shift-add: add multiplicand if current multiplier bit set, shift right.
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Restoring divide: bring next dividend bit into the remainder and trial-subtract.
    div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    // When the trial succeeds the difference is below the divisor, so WIDTH bits suffice.
    div_trial  = div_rem_sh[WIDTH-1:0] - opnd_q;
    if (div_q) begin
      if (div_rem_sh >= {1'b0, opnd_q}) begin
        acc_step = {div_trial, acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      div_q  <= 1'b0;
    end else if (start) begin
      acc_q  <= {{WIDTH{1'b0}}, (mode_div ? op_a : op_b)};
      opnd_q <= mode_div ? op_b : op_a;
      cnt_q  <= CNT_W'(WIDTH);
      run_q  <= 1'b1;
      div_q  <= mode_div;
    end else if (run_q) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        run_q <= 1'b0;
      end
    end
  end

  assign done   = run_q && (cnt_q == CNT_W'(1));
  assign res_lo = acc_step[WIDTH-1:0];
  assign res_hi = acc_step[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/arithunit_seq.sv
// Sequential arithmetic unit: ADD/SUB in one cycle, MUL/DIV iteratively,
// with valid/ready handshakes on request and result.
// Ports:
//   clk, reset                 : clock, synchronous active-low reset
//   in_valid, in_ready         : request handshake (ready only when idle)
//   data_1, data_2, op_sel     : operands A/B and opcode (ADD/SUB/MUL/DIV)
//   out_valid, out_ready       : result handshake
//   data_out, data_out_hi      : low result / high word (MUL upper, DIV remainder)
//   carry, div_by_zero         : ADD carry or SUB borrow; DIV with zero divisor
module arithunit_seq
  import arithunit_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic [1:0]       op_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] data_out_hi,
  output logic             carry,
  output logic             div_by_zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] dout_hi_q, dout_hi_d;
  logic             carry_q, carry_d;
  logic             dbz_q, dbz_d;

  logic             eng_start;
  logic             eng_done;
  logic [WIDTH-1:0] eng_lo;
  logic [WIDTH-1:0] eng_hi;
  logic [WIDTH:0]   add_sum;

  assign add_sum = {1'b0, data_1} + {1'b0, data_2};

  arith_iter_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start    (eng_start),
    .mode_div (op_sel == OP_DIV),
    .op_a     (data_1),
    .op_b     (data_2),
    .done     (eng_done),
    .res_lo   (eng_lo),
    .res_hi   (eng_hi)
  );

  always_comb begin
    state_d   = state_q;
    dout_d    = dout_q;
    dout_hi_d = dout_hi_q;
    carry_d   = carry_q;
    dbz_d     = dbz_q;
    eng_start = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          unique case (op_sel)
            OP_ADD: begin
              dout_d    = add_sum[WIDTH-1:0];
              dout_hi_d = '0;
              carry_d   = add_sum[WIDTH];
              dbz_d     = 1'b0;
              state_d   = S_DONE;
            end
            OP_SUB: begin
              dout_d    = data_1 - data_2;
              dout_hi_d = '0;
              carry_d   = data_1 < data_2;
              dbz_d     = 1'b0;
              state_d   = S_DONE;
            end
            OP_MUL: begin
              eng_start = 1'b1;
              state_d   = S_BUSY;
            end
            OP_DIV: begin
              if (data_2 == '0) begin
                dout_d    = '1;
                dout_hi_d = data_1;
                carry_d   = 1'b0;
                dbz_d     = 1'b1;
                state_d   = S_DONE;
              end else begin
                eng_start = 1'b1;
                state_d   = S_BUSY;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_BUSY: begin
        // Result is taken straight from the final iteration, so DONE follows immediately.
        if (eng_done) begin
          dout_d    = eng_lo;
          dout_hi_d = eng_hi;
          carry_d   = 1'b0;
          dbz_d     = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      dout_q    <= '0;
      dout_hi_q <= '0;
      carry_q   <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dout_q    <= dout_d;
      dout_hi_q <= dout_hi_d;
      carry_q   <= carry_d;
      dbz_q     <= dbz_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign data_out    = dout_q;
  assign data_out_hi = dout_hi_q;
  assign carry       = carry_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_arithunit_seq.sv
// Self-checking bench for arithunit_seq (WIDTH=16): directed vector table,
// randomized operations against a plain-arithmetic model, and hand-written
// backpressure and mid-operation reset sequences.
module tb_arithunit_seq;
  import arithunit_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_1;
  logic [W-1:0] data_2;
  logic [1:0]   op_sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] data_out;
  logic [W-1:0] data_out_hi;
  logic         carry;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
    int           lat;
  } res_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    res_t         exp;
  } vec_t;

  arithunit_seq #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_1      (data_1),
    .data_2      (data_2),
    .op_sel      (op_sel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .data_out_hi (data_out_hi),
    .carry       (carry),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference results straight from the arithmetic definitions.
  function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    res_t r;
    longint unsigned ua, ub, t;
    ua = a;
    ub = b;
    r.lo = '0; r.hi = '0; r.c = 1'b0; r.z = 1'b0; r.lat = 1;
    case (op)
      2'd0: begin
        t = ua + ub;
        r.lo = W'(t);
        r.c = (t >> W) != 0;
      end
      2'd1: begin
        r.lo = W'(ua - ub);
        r.c = ua < ub;
      end
      2'd2: begin
        t = ua * ub;
        r.lo = W'(t);
        r.hi = W'(t >> W);
        r.lat = W + 1;
      end
      default: begin
        if (ub == 0) begin
          r.lo = '1;
          r.hi = a;
          r.z = 1'b1;
        end else begin
          r.lo = W'(ua / ub);
          r.hi = W'(ua % ub);
          r.lat = W + 1;
        end
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request, measure latency from the accept edge, capture result, then handshake.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output res_t got, output bit ready_low);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1;
    op_sel   = op;
    data_1   = a;
    data_2   = b;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    data_1    = W'($urandom);
    data_2    = W'($urandom);
    op_sel    = 2'($urandom);
    got.lat   = 1;
    ready_low = !in_ready;
    while (!out_valid && got.lat < 40) begin
      if (in_ready) ready_low = 1'b0;
      @(posedge clk); #1;
      got.lat++;
    end
    got.lo = data_out;
    got.hi = data_out_hi;
    got.c  = carry;
    got.z  = div_by_zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic compare(input string tag, input res_t got, input res_t exp, input bit rl);
    chk({tag, " data_out"}, got.lo, exp.lo);
    chk({tag, " data_out_hi"}, got.hi, exp.hi);
    chk({tag, " carry"}, got.c, exp.c);
    chk({tag, " div_by_zero"}, got.z, exp.z);
    chk({tag, " latency"}, got.lat, exp.lat);
    chk({tag, " in_ready low while busy"}, rl, 1);
  endtask

  vec_t vecs[10];

  initial begin
    res_t got;
    res_t exp;
    bit   rl;
    logic [1:0]   op;
    logic [W-1:0] a, b;

    vecs[0] = '{op: OP_ADD, a: 16'hFFFF, b: 16'h0001,
                exp: '{lo: 16'h0000, hi: 16'h0000, c: 1'b1, z: 1'b0, lat: 1}};
    vecs[1] = '{op: OP_SUB, a: 16'd3, b: 16'd5,
                exp: '{lo: 16'hFFFE, hi: 16'h0000, c: 1'b1, z: 1'b0, lat: 1}};
    vecs[2] = '{op: OP_SUB, a: 16'd9, b: 16'd4,
                exp: '{lo: 16'h0005, hi: 16'h0000, c: 1'b0, z: 1'b0, lat: 1}};
    vecs[3] = '{op: OP_MUL, a: 16'h1234, b: 16'h0100,
                exp: '{lo: 16'h3400, hi: 16'h0012, c: 1'b0, z: 1'b0, lat: 17}};
    vecs[4] = '{op: OP_DIV, a: 16'd100, b: 16'd7,
                exp: '{lo: 16'd14, hi: 16'd2, c: 1'b0, z: 1'b0, lat: 17}};
    vecs[5] = '{op: OP_DIV, a: 16'h00AB, b: 16'h0000,
                exp: '{lo: 16'hFFFF, hi: 16'h00AB, c: 1'b0, z: 1'b1, lat: 1}};
    vecs[6] = '{op: OP_MUL, a: 16'h0000, b: 16'hFFFF,
                exp: '{lo: 16'h0000, hi: 16'h0000, c: 1'b0, z: 1'b0, lat: 17}};
    vecs[7] = '{op: OP_MUL, a: 16'hFFFF, b: 16'hFFFF,
                exp: '{lo: 16'h0001, hi: 16'hFFFE, c: 1'b0, z: 1'b0, lat: 17}};
    vecs[8] = '{op: OP_DIV, a: 16'hFFFF, b: 16'h0001,
                exp: '{lo: 16'hFFFF, hi: 16'h0000, c: 1'b0, z: 1'b0, lat: 17}};
    vecs[9] = '{op: OP_DIV, a: 16'd5, b: 16'd9,
                exp: '{lo: 16'd0, hi: 16'd5, c: 1'b0, z: 1'b0, lat: 17}};

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data_1 = '0; data_2 = '0; op_sel = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset data_out", data_out, 0);
    chk("reset data_out_hi", data_out_hi, 0);
    chk("reset carry", carry, 0);
    chk("reset div_by_zero", div_by_zero, 0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, got, rl);
      compare($sformatf("vec%0d", i), got, vecs[i].exp, rl);
    end

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = W'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? '0 :
           ($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 40)) : W'($urandom);
      exp = model(op, a, b);
      run_op(op, a, b, got, rl);
      compare($sformatf("rand%0d op%0d a=%0h b=%0h", i, op, a, b), got, exp, rl);
    end

    // Backpressure: ADD 2+3 held for 5 cycles while in_valid pulses are ignored.
    in_valid = 1'b1; op_sel = OP_ADD; data_1 = 16'd2; data_2 = 16'd3;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; op_sel = OP_MUL; data_1 = 16'd7; data_2 = 16'd7;
      chk($sformatf("stall%0d out_valid", k), out_valid, 1);
      chk($sformatf("stall%0d data_out", k), data_out, 5);
      chk($sformatf("stall%0d in_ready", k), in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    chk("stall final data_out", data_out, 5);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post-handshake in_ready", in_ready, 1);
    chk("post-handshake out_valid", out_valid, 0);
    chk("post-handshake data_out kept", data_out, 5);

    // Reset in the 6th BUSY cycle of a MUL discards it.
    in_valid = 1'b1; op_sel = OP_MUL; data_1 = 16'h0FFF; data_2 = 16'h0FFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mul accepted", in_ready, 0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("abort in_ready", in_ready, 1);
    chk("abort out_valid", out_valid, 0);
    chk("abort data_out", data_out, 0);
    chk("abort data_out_hi", data_out_hi, 0);
    chk("abort carry", carry, 0);
    chk("abort div_by_zero", div_by_zero, 0);
    exp = '{lo: 16'd2, hi: 16'd0, c: 1'b0, z: 1'b0, lat: 1};
    run_op(OP_ADD, 16'd1, 16'd1, got, rl);
    compare("after-abort add", got, exp, rl);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
